// File: rtl/led_frame_sequencer_if.sv
// led_frame_sequencer_if: frame buffer write bus
// master drives valid/addr/data, slave returns ready; a write lands when valid & ready
interface led_frame_sequencer_if #(
   parameter int NUM_FRAMES = 4
);
   localparam int AW = $clog2(NUM_FRAMES);
   logic          valid;
   logic          ready;
   logic [AW-1:0] addr;
   logic [35:0]   data;
   modport master(output valid, addr, data, input ready);
   modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: plays buffered 6x6 frames into the LED matrix driver
// ports: clk, rst (async, active high); wr (frame write bus, slave side);
//   start/stop/loop_en playback control; frame_count/hold_ticks latched at start;
//   tick timebase pulse; img/frame_idx displayed frame; busy/frame_strobe/done status
module led_frame_sequencer #(
   parameter int NUM_FRAMES = 4,
   parameter int HOLD_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   led_frame_sequencer_if.slave          wr,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          loop_en,
   input  logic [$clog2(NUM_FRAMES):0]   frame_count,
   input  logic [HOLD_W-1:0]             hold_ticks,
   input  logic                          tick,
   output logic [35:0]                   img,
   output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
   output logic                          busy,
   output logic                          frame_strobe,
   output logic                          done
);
   localparam int AW = $clog2(NUM_FRAMES);
   typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;
   state_t state, state_n;
   logic [35:0] frames [NUM_FRAMES];
   logic [35:0] img_n;
   logic [AW-1:0] idx_n;
   logic [AW:0] cnt_q, cnt_n;
   logic [HOLD_W-1:0] hold_q, hold_n, hcnt, hcnt_n;
   logic strobe_n, adv, last, start_ok;
   assign busy = state != IDLE;
   assign done = state == FINISH;
   // the slot on screen cannot be overwritten while it is being held
   assign wr.ready = state != HOLD || wr.addr != frame_idx;
   assign start_ok = start && !stop && frame_count != '0 && frame_count <= (AW+1)'(NUM_FRAMES);
   assign adv = tick && hcnt == hold_q - HOLD_W'(1);
   assign last = {1'b0, frame_idx} == cnt_q - (AW+1)'(1);
   always_comb begin
      state_n = state;
      img_n = img;
      idx_n = frame_idx;
      cnt_n = cnt_q;
      hold_n = hold_q;
      hcnt_n = hcnt;
      strobe_n = 1'b0;
      case (state)
         IDLE: if (start_ok) begin
            state_n = HOLD;
            cnt_n = frame_count;
            hold_n = hold_ticks == '0 ? HOLD_W'(1) : hold_ticks;
            idx_n = '0;
            img_n = frames[0];
            hcnt_n = '0;
            strobe_n = 1'b1;
         end
         HOLD: if (stop) begin
            state_n = IDLE;
            img_n = '0;
            idx_n = '0;
            hcnt_n = '0;
         end else if (adv) begin
            hcnt_n = '0;
            if (!last || loop_en) begin
               idx_n = last ? '0 : frame_idx + AW'(1);
               // registered load reads the pre-write contents of the slot
               img_n = frames[idx_n];
               strobe_n = 1'b1;
            end else begin
               state_n = FINISH;
            end
         end else if (tick) begin
            hcnt_n = hcnt + HOLD_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         img <= '0;
         frame_idx <= '0;
         cnt_q <= '0;
         hold_q <= '0;
         hcnt <= '0;
         frame_strobe <= 1'b0;
      end else begin
         state <= state_n;
         img <= img_n;
         frame_idx <= idx_n;
         cnt_q <= cnt_n;
         hold_q <= hold_n;
         hcnt <= hcnt_n;
         frame_strobe <= strobe_n;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_FRAMES; i++) frames[i] <= '0;
      end else if (wr.valid && wr.ready) begin
         frames[wr.addr] <= wr.data;
      end
   end
endmodule

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 Parameter NUM_FRAMES, default 4, is the number of 36-bit frame buffer slots (2..8).
REQ-002 Parameter HOLD_W, default 8, is the width of the per-frame hold count.
REQ-003 Port clk, input, 1, is the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, is the asynchronous active-high reset.
REQ-005 Port wr_valid, input, 1, is the frame write request.
REQ-006 Port wr_ready, output, 1, signals that the write is accepted this cycle.
REQ-007 Port wr_addr, input, clog2(NUM_FRAMES), is the target slot.
REQ-008 Port wr_data, input, 36, is the frame image (bit n = pixel n, row-major 6x6, bit 0 top-left).
REQ-009 Port start, input, 1, is the play request pulse.
REQ-010 Port stop, input, 1, is the abort request.
REQ-011 Port loop_en, input, 1, selects wrap-around playback; it is sampled live.
REQ-012 Port frame_count, input, clog2(NUM_FRAMES)+1, gives the number of slots to play; it is latched at start.
REQ-013 Port hold_ticks, input, HOLD_W, gives the ticks per frame; it is latched at start.
REQ-014 Port tick, input, 1, is a 1-cycle timebase pulse from the clock divider.
REQ-015 Port img, output, 36, is the image driven into the 6x6 matrix driver.
REQ-016 Port frame_idx, output, clog2(NUM_FRAMES), is the slot currently shown.
REQ-017 Port busy, output, 1, is high in any state except IDLE.
REQ-018 Port frame_strobe, output, 1, is a 1-cycle pulse whenever img is loaded from the buffer.
REQ-019 Port done, output, 1, is a 1-cycle pulse at normal end of a non-looping sequence.

Function
REQ-020 The state machine SHALL have exactly the states IDLE, HOLD and FINISH.
REQ-021 Write acceptance SHALL be the condition wr_valid & wr_ready; the slot SHALL update at that edge.
REQ-022 wr_ready SHALL be 1 in IDLE and FINISH, and 1 in HOLD unless wr_addr == frame_idx (the displayed slot is write-protected).
REQ-023 In IDLE, start with 1 <= frame_count <= NUM_FRAMES SHALL, at the next edge, latch frame_count and hold_ticks, and set img = buf[0], frame_idx = 0, hold counter = 0, frame_strobe = 1 and state = HOLD.
REQ-024 In IDLE, start with frame_count == 0 or frame_count > NUM_FRAMES SHALL be ignored (state stays IDLE).
REQ-025 A latched hold_ticks of 0 SHALL be treated as 1.
REQ-026 In HOLD, each tick SHALL increment the hold counter; the tick on which the counter equals hold-1 is the advance tick.
REQ-027 On the advance tick, if frame_idx < count-1, the block SHALL set frame_idx + 1, img = buf[frame_idx + 1], hold counter = 0 and frame_strobe = 1 at the next edge.
REQ-028 On the advance tick at the last frame with loop_en = 1, the block SHALL wrap to frame_idx = 0, load img = buf[0] and pulse frame_strobe.
REQ-029 On the advance tick at the last frame with loop_en = 0, the block SHALL go to FINISH with img unchanged.
REQ-030 FINISH SHALL last exactly one cycle with done = 1, then go to IDLE; img SHALL keep the last frame.
REQ-031 A buffer read for an img load SHALL return the slot contents before any write accepted in the same cycle.
REQ-032 stop in HOLD SHALL force, at the next edge, state = IDLE, img = 0 and frame_idx = 0, with no done or frame_strobe.
REQ-033 stop SHALL have priority over tick and advance.
REQ-034 start SHALL be ignored outside IDLE.
REQ-035 A start and stop asserted together in IDLE SHALL leave the state in IDLE.
REQ-036 tick SHALL be ignored in IDLE and FINISH.
REQ-037 Latency from an accepted start to img valid SHALL be 1 cycle, and from the advance tick to the new img 1 cycle.

Reset
REQ-038 rst high SHALL immediately force state = IDLE, img = 0, frame_idx = 0, busy = 0, frame_strobe = 0, done = 0, hold counter = 0, latched count/hold = 0, and all buffer slots = 0.
REQ-039 rst asserted mid-sequence SHALL abort playback without a done pulse.
REQ-040 After rst falls, the first start SHALL behave per REQ-023.

Verification
REQ-041 Write slots 0..3 = 36'h1, 36'h2, 36'h4, 36'h8; start with count = 4, hold = 2, loop_en = 0, tick every 10 cycles -> img steps 1,2,4,8 with 2 ticks each, 4 frame_strobes, one done, img stays 36'h8, busy falls.
REQ-042 Same as REQ-041 with loop_en = 1 -> after 36'h8, img = 36'h1 and frame_idx = 0 (wrap), busy stays 1; stop asserted coincident with a tick -> next cycle img = 0, IDLE, no done.
REQ-043 During HOLD on slot 1, write slot 1 -> wr_ready = 0 and slot unchanged; write slot 2 -> wr_ready = 1 and new data shown when frame 2 loads.
REQ-044 Start with count = 0 and start with count = NUM_FRAMES+1 -> busy stays 0; hold = 0 -> each frame lasts 1 tick.
REQ-045 Assert rst asynchronously mid-HOLD -> outputs and buffer zero with no clock edge; release, rewrite, start -> normal playback.
